ldpc_debug_ocimem_ctrl: RTL and testbench

Downstream consumer of the Nios II debug-slave command strobes (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a) in the LDPC system.
- Owns a single-port debug RAM shared between the JTAG debugger and the CPU-side Avalon slave.
- Returns read data and status to the debug slave via MonDReg, monitor_ready and monitor_error.
- JTAG commands always take priority; the CPU port is stalled with waitrequest.

---
 rtl/ldpc_debug_ocimem_ctrl.sv | 151 +++++++++++++++
 tb/tb_ldpc_debug_ocimem_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_debug_ocimem_ctrl.sv
// Debug RAM controller for the LDPC system's Nios II debug slave.
// JTAG strobes always own the single RAM port; the CPU Avalon slave is stalled while they do.
module ldpc_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        JRD,
        CPU_RD
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_jtagAddr;
    logic [31:0]       r_q;
    logic [31:0]       r_monDReg;
    logic              r_monReady;
    logic              r_monError;
    logic              r_ackPend;
    logic              r_errPend;
    logic [31:0]       r_mem [DEPTH];

    logic              w_selA;
    logic              w_selN;
    logic              w_selB;
    logic              w_anyStrobe;
    logic [ADDR_W-1:0] w_newAddr;
    logic              w_jtagRd;
    logic              w_jtagWr;
    logic              w_jtagErr;
    logic              w_cpuRd;
    logic              w_cpuWr;
    logic              w_ramRd;
    logic [ADDR_W-1:0] w_ramAddr;
    logic              w_unusedJdo;

    // Only the highest-priority strobe is acted on; b > a > no_action.
    assign w_selB      = take_action_ocimem_b;
    assign w_selA      = take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_selN      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_anyStrobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_newAddr   = jdo[17 +: ADDR_W];
    assign w_unusedJdo = &{1'b0, jdo[37:36], jdo[2:0]};

    assign w_jtagRd  = (w_selA & jdo[34]) | w_selN;
    assign w_jtagWr  = w_selB & debugack;
    assign w_jtagErr = w_selB & ~debugack;

    // The port is idle during JRD and CPU_RD (data already sits in r_q), so a
    // CPU read may be launched from JRD; CPU writes wait until JRD has retired.
    assign w_cpuRd   = read & ~w_anyStrobe & (r_state != CPU_RD);
    assign w_cpuWr   = write & ~w_anyStrobe & (r_state != JRD);
    assign w_ramRd   = w_jtagRd | w_cpuRd;
    assign w_ramAddr = w_anyStrobe ? (w_selA ? w_newAddr : r_jtagAddr) : address;

    assign waitrequest = (read  & (w_anyStrobe | (r_state != CPU_RD)))
                       | (write & (w_anyStrobe | (r_state == JRD)));

    assign readdata      = r_q;
    assign MonDReg       = r_monDReg;
    assign monitor_ready = r_monReady;
    assign monitor_error = r_monError;

    always_comb begin
        w_nextState = IDLE;
        if (w_jtagRd) begin
            w_nextState = JRD;
        end else if (w_cpuRd) begin
            w_nextState = CPU_RD;
        end
    end

    // RAM array is not reset; JTAG writes full words, CPU writes per byte lane.
    always_ff @(posedge clk) begin
        if (w_jtagWr) begin
            r_mem[r_jtagAddr] <= jdo[34:3];
        end else if (w_cpuWr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_jtagAddr <= '0;
            r_q        <= '0;
            r_monDReg  <= '0;
            r_monReady <= 1'b0;
            r_monError <= 1'b0;
            r_ackPend  <= 1'b0;
            r_errPend  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ackPend <= w_jtagWr | w_jtagErr;
            r_errPend <= w_jtagErr;

            if (w_ramRd) begin
                r_q <= r_mem[w_ramAddr];
            end

            if (w_selA) begin
                r_jtagAddr <= w_newAddr;
            end else if (w_selN | w_jtagWr) begin
                r_jtagAddr <= r_jtagAddr + ADDR_W'(1);
            end

            if (r_state == JRD) begin
                r_monDReg <= r_q;
            end

            // A new access drops ready even if the previous one retires this edge.
            if (w_jtagRd | w_selB) begin
                r_monReady <= 1'b0;
            end else if ((r_state == JRD) | r_ackPend) begin
                r_monReady <= 1'b1;
            end

            if (w_selA & jdo[35]) begin
                r_monError <= 1'b0;
            end else if (r_errPend) begin
                r_monError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_debug_ocimem_ctrl.sv
// Self-checking bench for ldpc_debug_ocimem_ctrl: JTAG vector table with a
// response scoreboard, plus hand-written CPU, arbitration and reset sequences.
module tb_ldpc_debug_ocimem_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              debugack;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    typedef struct {
        logic [2:0]  strb;      // {b, a, no_action}
        logic [37:0] jdoVal;
        logic        dack;
        logic        resp;      // a ready handshake is expected
        logic [31:0] expMon;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] mon;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] cpuQ[$];
    vec_t        vecs[$];
    logic [31:0] mdl [256];
    int          errors = 0;
    int          checks = 0;

    ldpc_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .debugack               (debugack),
        .address                (address),
        .read                   (read),
        .write                  (write),
        .writedata              (writedata),
        .byteenable             (byteenable),
        .readdata               (readdata),
        .waitrequest            (waitrequest),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [37:0] mkA(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j        = '0;
        j[35]    = clr;
        j[34]    = rd;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] mkB(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    function automatic vec_t vA(input logic [7:0] a, input logic rd, input logic clr,
                                input logic [31:0] mon, input logic err);
        vec_t v;
        v.strb = 3'b010; v.jdoVal = mkA(a, rd, clr); v.dack = 1'b1;
        v.resp = rd; v.expMon = mon; v.expErr = err;
        return v;
    endfunction

    function automatic vec_t vN(input logic [31:0] mon, input logic err);
        vec_t v;
        v.strb = 3'b001; v.jdoVal = '0; v.dack = 1'b1;
        v.resp = 1'b1; v.expMon = mon; v.expErr = err;
        return v;
    endfunction

    function automatic vec_t vB(input logic [31:0] d, input logic dack,
                                input logic [31:0] mon, input logic err);
        vec_t v;
        v.strb = 3'b100; v.jdoVal = mkB(d); v.dack = dack;
        v.resp = 1'b1; v.expMon = mon; v.expErr = err;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one strobe for a single cycle and queues the expected handshake.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        debugack                = v.dack;
        jdo                     = v.jdoVal;
        take_action_ocimem_b    = v.strb[2];
        take_action_ocimem_a    = v.strb[1];
        take_no_action_ocimem_a = v.strb[0];
        if (v.resp) begin
            expQ.push_back('{mon: v.expMon, err: v.expErr});
        end
        @(negedge clk);
        take_action_ocimem_b    = 1'b0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo                     = '0;
        if (v.resp) begin
            compare("readyLowAtStrobe", monitor_ready, 1'b0);
        end else begin
            compare("errorAfterAddrLoad", monitor_error, v.expErr);
        end
    endtask

    // Waits (bounded) for monitor_ready and compares against the scoreboard head.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) return;
        for (int i = 0; i < 4 && !monitor_ready; i++) @(negedge clk);
        e = expQ.pop_front();
        if (!monitor_ready) begin
            compare("readyTimeout", monitor_ready, 1'b1);
        end else begin
            compare("MonDReg", MonDReg, e.mon);
            compare("monitorError", monitor_error, e.err);
        end
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                            input int expCycles);
        int n = 0;
        bit done = 0;
        @(negedge clk);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n++;
            if (!waitrequest) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        compare("cpuWrDone", done, 1'b1);
        compare("cpuWrCycles", n, expCycles);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic cpuRead(input logic [7:0] a, input int expCycles);
        int n = 0;
        bit done = 0;
        logic [31:0] e;
        @(negedge clk);
        address = a; read = 1'b1;
        cpuQ.push_back(mdl[a]);
        for (int i = 0; i < 8; i++) begin
            #1;
            n++;
            if (!waitrequest) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        e = cpuQ.pop_front();
        compare("cpuRdDone", done, 1'b1);
        compare("cpuRdData", readdata, e);
        compare("cpuRdCycles", n, expCycles);
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        vec_t pv;
        logic [31:0] e;

        reset_n = 1'b0;
        jdo = '0; take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0; debugack = 1'b1;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;

        // JTAG vector table; expected MonDReg/error derived by hand from the command history.
        vecs.push_back(vA(8'h10, 1'b0, 1'b0, 32'h0, 1'b0));
        vecs.push_back(vB(32'hDEADBEEF, 1'b1, 32'h0, 1'b0));
        vecs.push_back(vB(32'h11111111, 1'b1, 32'h0, 1'b0));
        vecs.push_back(vB(32'h22222222, 1'b1, 32'h0, 1'b0));
        vecs.push_back(vA(8'h10, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(vN(32'hDEADBEEF, 1'b0));
        vecs.push_back(vN(32'h11111111, 1'b0));
        vecs.push_back(vN(32'h22222222, 1'b0));
        vecs.push_back(vA(8'hFF, 1'b0, 1'b0, 32'h22222222, 1'b0));
        vecs.push_back(vB(32'hCAFEF00D, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(vB(32'h0BADC0DE, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(vA(8'hFF, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0));
        vecs.push_back(vN(32'hCAFEF00D, 1'b0));
        vecs.push_back(vN(32'h0BADC0DE, 1'b0));
        vecs.push_back(vA(8'h10, 1'b0, 1'b0, 32'h0BADC0DE, 1'b0));
        vecs.push_back(vB(32'h55555555, 1'b0, 32'h0BADC0DE, 1'b1));
        vecs.push_back(vN(32'hDEADBEEF, 1'b1));
        vecs.push_back(vA(8'h12, 1'b1, 1'b0, 32'h22222222, 1'b1));
        vecs.push_back(vA(8'h10, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0));
        // All three strobes together: b must win (jdo[24:17]=0x40 would be a's address).
        pv = vB(32'h00100000, 1'b1, 32'hDEADBEEF, 1'b0);
        pv.strb = 3'b111;
        vecs.push_back(pv);
        vecs.push_back(vA(8'h10, 1'b1, 1'b0, 32'h00100000, 1'b0));

        repeat (3) @(negedge clk);
        compare("rstMonDReg", MonDReg, 32'h0);
        compare("rstReady", monitor_ready, 1'b0);
        compare("rstError", monitor_error, 1'b0);
        compare("rstReaddata", readdata, 32'h0);
        compare("rstWait", waitrequest, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        $display("[TB] CPU port sequences");
        cpuWrite(8'h20, 32'h12345678, 4'b1111, 1);
        cpuWrite(8'h20, 32'h0000A5A5, 4'b0011, 1);
        cpuRead(8'h20, 2);
        cpuWrite(8'h21, 32'hA1B2C3D4, 4'b1111, 1);
        cpuRead(8'h21, 2);
        applyStimulus(vA(8'h20, 1'b1, 1'b0, 32'h1234A5A5, 1'b0));
        checkOutput();

        $display("[TB] strobe collides with CPU read");
        @(negedge clk);
        address = 8'h20; read = 1'b1;
        take_action_ocimem_a = 1'b1; jdo = mkA(8'h21, 1'b1, 1'b0);
        expQ.push_back('{mon: 32'hA1B2C3D4, err: 1'b0});
        cpuQ.push_back(mdl[8'h20]);
        #1;
        compare("collideWait0", waitrequest, 1'b1);
        @(negedge clk);
        take_action_ocimem_a = 1'b0; jdo = '0;
        #1;
        compare("collideWait1", waitrequest, 1'b1);
        compare("collideReadyLow", monitor_ready, 1'b0);
        @(negedge clk);
        #1;
        compare("collideWait2", waitrequest, 1'b0);
        e = cpuQ.pop_front();
        compare("collideReaddata", readdata, e);
        checkOutput();
        @(negedge clk);
        read = 1'b0;

        applyStimulus(vB(32'h99999999, 1'b0, 32'hA1B2C3D4, 1'b1));
        checkOutput();

        $display("[TB] reset during JTAG read");
        @(negedge clk);
        take_action_ocimem_a = 1'b1; jdo = mkA(8'h20, 1'b1, 1'b0);
        @(negedge clk);
        take_action_ocimem_a = 1'b0; jdo = '0;
        reset_n = 1'b0;
        #1;
        compare("midRstReady", monitor_ready, 1'b0);
        compare("midRstMonDReg", MonDReg, 32'h0);
        compare("midRstError", monitor_error, 1'b0);
        compare("midRstReaddata", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        compare("postRstReady", monitor_ready, 1'b0);

        applyStimulus(vN(32'h0BADC0DE, 1'b0));
        checkOutput();
        applyStimulus(vA(8'h20, 1'b1, 1'b0, 32'h1234A5A5, 1'b0));
        checkOutput();
        cpuRead(8'h21, 2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
